// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
//
// Purpose: groups the MEM-stage -> writeback-stage bus that feeds the MEM/WB
// pipeline register, together with the pipeline control lines (stall, flush).
//
// Signal summary:
//   ex_mem_valid       MEM stage holds a real instruction
//   ex_mem_wb_ctl[1:0] [1]=regwrite, [0]=memtoreg
//   ex_mem_alu_result  ALU result / effective address
//   ex_mem_readdata    raw word read from data memory
//   ex_mem_rd          destination register
//   ex_mem_funct3      load width / sign code
//   stall              hold MEM/WB contents
//   flush              invalidate MEM/WB contents
//
// Transfer semantics: there is no ready signal. Whenever neither stall nor
// flush is high, the writeback stage captures the bus at the rising edge;
// ex_mem_valid qualifies whether the captured contents are a real
// instruction. ex_mem_readdata must be settled in the same cycle as the
// instruction it belongs to.
//
// Modports:
//   master  MEM stage / pipeline control (drives everything)
//   slave   writeback stage (observes everything)
// ---------------------------------------------------------------------------
interface writeback_stage_if;
    logic        ex_mem_valid;
    logic [1:0]  ex_mem_wb_ctl;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_readdata;
    logic [4:0]  ex_mem_rd;
    logic [2:0]  ex_mem_funct3;
    logic        stall;
    logic        flush;

    modport master (
        output ex_mem_valid,
        output ex_mem_wb_ctl,
        output ex_mem_alu_result,
        output ex_mem_readdata,
        output ex_mem_rd,
        output ex_mem_funct3,
        output stall,
        output flush
    );

    modport slave (
        input ex_mem_valid,
        input ex_mem_wb_ctl,
        input ex_mem_alu_result,
        input ex_mem_readdata,
        input ex_mem_rd,
        input ex_mem_funct3,
        input stall,
        input flush
    );
endinterface : writeback_stage_if

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Purpose: final pipeline stage. Holds the MEM/WB pipeline register, aligns
// and sign/zero-extends load data, selects the register-file write data and
// drives the register-file write port of the decode stage. It also keeps a
// one-entry record of the write committed on the previous edge (so decode
// can bypass a same-edge register-file write) and a retired-instruction
// counter.
//
// Ports:
//   clock              rising-edge clock
//   reset              asynchronous, active-high reset
//   ex_mem             MEM-stage bus + stall/flush (writeback_stage_if.slave)
//   mem_wb_rd          write address to register file (registered rd)
//   mem_wb_regwrite    write enable to register file
//   wb_mux5_writedata  write data to register file
//   last_valid         last_rd/last_data hold a write committed last edge
//   last_rd            address of that write
//   last_data          data of that write
//   retired_count      instructions retired since reset (wraps)
//
// Parameters:
//   COUNT_WIDTH        width of retired_count
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    writeback_stage_if.slave       ex_mem,
    output logic [4:0]             mem_wb_rd,
    output logic                   mem_wb_regwrite,
    output logic [31:0]            wb_mux5_writedata,
    output logic                   last_valid,
    output logic [4:0]             last_rd,
    output logic [31:0]            last_data,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    // -----------------------------------------------------------------------
    // MEM/WB pipeline register
    // -----------------------------------------------------------------------
    logic        valid_q,    valid_d;
    // written_q marks an instruction that has already spent one cycle in WB
    // (it was held there by a stall). Such an instruction must neither write
    // the register file again nor be counted again.
    logic        written_q,  written_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [31:0] alu_q,      alu_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [4:0]  rd_q,       rd_d;
    logic [2:0]  funct3_q,   funct3_d;

    // -----------------------------------------------------------------------
    // Last-committed-write record and retire counter
    // -----------------------------------------------------------------------
    logic                   last_valid_q, last_valid_d;
    logic [4:0]             last_rd_q,    last_rd_d;
    logic [31:0]            last_data_q,  last_data_d;
    logic [COUNT_WIDTH-1:0] count_q,      count_d;

    // -----------------------------------------------------------------------
    // Combinational datapath from the registered fields
    // -----------------------------------------------------------------------
    logic        first_cycle;   // valid instruction in its first WB cycle
    logic        write_en;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] write_data;

    assign first_cycle = valid_q & ~written_q;
    // Writes to x0 are suppressed here so the register file never sees them.
    assign write_en    = first_cycle & regwrite_q & (rd_q != 5'd0);

    // Byte lane select: byte k of the little-endian word is bits 8k+7:8k.
    always_comb begin
        load_byte = rdata_q[7:0];
        unique case (alu_q[1:0])
            2'd0: load_byte = rdata_q[7:0];
            2'd1: load_byte = rdata_q[15:8];
            2'd2: load_byte = rdata_q[23:16];
            2'd3: load_byte = rdata_q[31:24];
        endcase
    end

    // Halfword lane select: only address bit 1 matters, bit 0 is ignored.
    assign load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    // Width / sign handling; every code not listed is a plain word load.
    always_comb begin
        load_value = rdata_q;
        case (funct3_q)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_value = {24'h000000, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b101:  load_value = {16'h0000, load_half};
            default: load_value = rdata_q;
        endcase
    end

    assign write_data = memtoreg_q ? load_value : alu_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Default: everything holds.
        valid_d    = valid_q;
        written_d  = written_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;

        if (ex_mem.flush) begin
            // Flush wins over stall. The data fields simply hold; they are
            // meaningless once valid is cleared.
            valid_d   = 1'b0;
            written_d = 1'b0;
        end else if (ex_mem.stall) begin
            // After one stalled edge the held instruction has had its write
            // and its retire; mark it so neither repeats.
            if (valid_q) begin
                written_d = 1'b1;
            end
        end else begin
            valid_d    = ex_mem.ex_mem_valid;
            written_d  = 1'b0;
            regwrite_d = ex_mem.ex_mem_wb_ctl[1];
            memtoreg_d = ex_mem.ex_mem_wb_ctl[0];
            alu_d      = ex_mem.ex_mem_alu_result;
            rdata_d    = ex_mem.ex_mem_readdata;
            rd_d       = ex_mem.ex_mem_rd;
            funct3_d   = ex_mem.ex_mem_funct3;
        end
    end

    always_comb begin
        // last_rd/last_data keep their old contents when nothing is written;
        // only last_valid drops, so decode ignores the stale record.
        last_valid_d = write_en;
        last_rd_d    = last_rd_q;
        last_data_d  = last_data_q;
        if (write_en) begin
            last_rd_d   = rd_q;
            last_data_d = write_data;
        end
    end

    // Every instruction retires once, in its first WB cycle, whether or not
    // it writes a register. A flush on the same edge does not undo that.
    always_comb begin
        count_d = count_q;
        if (first_cycle) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            written_q    <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            alu_q        <= 32'h0;
            rdata_q      <= 32'h0;
            rd_q         <= 5'd0;
            funct3_q     <= 3'd0;
            last_valid_q <= 1'b0;
            last_rd_q    <= 5'd0;
            last_data_q  <= 32'h0;
            count_q      <= '0;
        end else begin
            valid_q      <= valid_d;
            written_q    <= written_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            last_valid_q <= last_valid_d;
            last_rd_q    <= last_rd_d;
            last_data_q  <= last_data_d;
            count_q      <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_wb_rd         = rd_q;
    assign mem_wb_regwrite   = write_en;
    assign wb_mux5_writedata = write_data;
    assign last_valid        = last_valid_q;
    assign last_rd           = last_rd_q;
    assign last_data         = last_data_q;
    assign retired_count     = count_q;

endmodule : writeback_stage
